hazard_ctrl_seq: RTL and testbench

//  Next-generation pipeline hazard controller for the 5-stage core. It keeps the EX>MEM>WB forwarding
//  mux selects and adds state: multi-cycle load-use stall, memory wait-state freeze with timeout,
//  and branch flush that is deferred across a freeze. Sits beside the ID stage, drives all

---
 rtl/hazard_ctrl_seq.sv | 197 +++++++++++++++++++
 tb/tb_hazard_ctrl_seq.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_seq.sv
// Stateful hazard controller for the 5-stage core: forwarding selects, load-use stall, memory freeze
// with timeout, and deferred branch flush. Define HAZARD_PERF_CNT_EN to build the stall_cnt counter.
module hazard_ctrl_seq #(
  parameter int REG_AW      = 2,
  parameter bit IGNORE_REG0 = 1'b0,
  parameter int LOAD_LAT    = 1,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              ex_reg_write,
  input  logic              mem_reg_write,
  input  logic              wb_reg_write,
  input  logic              ex_mem_read,
  input  logic              mem_req,
  input  logic              mem_ready,
  input  logic              branch_taken,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b,
  output logic              stall_if,
  output logic              stall_id,
  output logic              stall_ex,
  output logic              stall_mem,
  output logic              bubble_ex,
  output logic              flush_id,
  output logic              mem_err,
  output logic [15:0]       stall_cnt
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LU_WAIT  = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam logic [2:0] LCNT_INIT = 3'(LOAD_LAT - 1);
  localparam logic [7:0] TIMEOUT   = 8'(MEM_TIMEOUT);

  state_t     state_q, state_d;
  logic [2:0] lcnt_q, lcnt_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic       pending_flush_q, pending_flush_d;

  logic       stall_front, stall_back, bubble, flush, err;
  logic       freeze_entry, flush_req, lu_hit;
  logic [7:0] wcnt_inc;
  logic [1:0] fwd_a_raw, fwd_b_raw;

  function automatic logic reg_match(input logic [REG_AW-1:0] rd, input logic wr,
                                     input logic [REG_AW-1:0] src);
    return wr && (rd == src) && !(IGNORE_REG0 && (src == '0));
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src);
    if (reg_match(ex_rd, ex_reg_write, src))        return 2'b11;
    else if (reg_match(mem_rd, mem_reg_write, src)) return 2'b01;
    else if (reg_match(wb_rd, wb_reg_write, src))   return 2'b10;
    else                                            return 2'b00;
  endfunction

  assign freeze_entry = mem_req && !mem_ready;
  assign flush_req    = branch_taken || pending_flush_q;
  assign lu_hit       = ex_mem_read &&
                        (reg_match(ex_rd, ex_reg_write, id_rs) || reg_match(ex_rd, ex_reg_write, id_rt));
  assign wcnt_inc     = (wcnt_q == 8'hFF) ? wcnt_q : wcnt_q + 8'd1;

  always_comb begin
    state_d         = state_q;
    lcnt_d          = lcnt_q;
    wcnt_d          = wcnt_q;
    pending_flush_d = pending_flush_q;
    stall_front     = 1'b0;
    stall_back      = 1'b0;
    bubble          = 1'b0;
    flush           = 1'b0;
    err             = 1'b0;
    case (state_q)
      IDLE, LU_WAIT: begin
        if (freeze_entry) begin
          stall_front = 1'b1;
          stall_back  = 1'b1;
          wcnt_d      = 8'd1;
          state_d     = MEM_WAIT;
          if (branch_taken) pending_flush_d = 1'b1;
        end else if (flush_req) begin
          flush           = 1'b1;
          bubble          = 1'b1;
          pending_flush_d = 1'b0;
          lcnt_d          = 3'd0;
          state_d         = IDLE;
        end else if (state_q == LU_WAIT) begin
          stall_front = 1'b1;
          bubble      = 1'b1;
          lcnt_d      = lcnt_q - 3'd1;
          if (lcnt_q <= 3'd1) begin
            lcnt_d  = 3'd0;
            state_d = IDLE;
          end
        end else if (lu_hit) begin
          stall_front = 1'b1;
          bubble      = 1'b1;
          if (LOAD_LAT > 1) begin
            lcnt_d  = LCNT_INIT;
            state_d = LU_WAIT;
          end
        end
      end
      MEM_WAIT: begin
        stall_front = 1'b1;
        stall_back  = 1'b1;
        if (branch_taken) pending_flush_d = 1'b1;
        // wcnt_inc is the number of wait cycles including this one
        if (mem_ready) begin
          wcnt_d  = 8'd0;
          state_d = (lcnt_q != 3'd0) ? LU_WAIT : IDLE;
        end else if (wcnt_inc >= TIMEOUT) begin
          err     = 1'b1;
          wcnt_d  = 8'd0;
          lcnt_d  = 3'd0;
          state_d = IDLE;
        end else begin
          wcnt_d = wcnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign fwd_a_raw = fwd_sel(id_rs);
  assign fwd_b_raw = fwd_sel(id_rt);

  // Outputs held at zero for as long as reset is asserted
  always_comb begin
    forward_a = 2'b00;
    forward_b = 2'b00;
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    stall_mem = 1'b0;
    bubble_ex = 1'b0;
    flush_id  = 1'b0;
    mem_err   = 1'b0;
    if (rst_n) begin
      stall_if  = stall_front;
      stall_id  = stall_front;
      stall_ex  = stall_back;
      stall_mem = stall_back;
      bubble_ex = bubble;
      flush_id  = flush;
      mem_err   = err;
      if (!stall_front && !flush) begin
        forward_a = fwd_a_raw;
        forward_b = fwd_b_raw;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      lcnt_q          <= 3'd0;
      wcnt_q          <= 8'd0;
      pending_flush_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      lcnt_q          <= lcnt_d;
      wcnt_q          <= wcnt_d;
      pending_flush_q <= pending_flush_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_if && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= 16'd0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_seq.sv
// Bench for hazard_ctrl_seq: two configurations share one input set and are checked every cycle
// against a cycle-count reference model, plus directed scenario checks and random traffic.
module tb_hazard_ctrl_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  id_rs, id_rt, ex_rd, mem_rd, wb_rd;
  logic        ex_rw, mem_rw, wb_rw, ex_mem_read, mem_req, mem_ready, branch_taken;

  logic [1:0]  a_fa, a_fb, b_fa, b_fb;
  logic        a_sif, a_sid, a_sex, a_smem, a_bub, a_fl, a_err;
  logic        b_sif, b_sid, b_sex, b_smem, b_bub, b_fl, b_err;
  logic [15:0] a_cnt, b_cnt;
  logic [10:0] a_live, b_live, a_o, b_o;
  logic [15:0] a_c, b_c;

  int vectors = 0;
  int miscompares = 0;
  int stall_seen;

  // Reference model state per configuration (0 = dut_a, 1 = dut_b)
  int lu_rem[2];
  int waited[2];
  int perf[2];
  bit frozen[2];
  bit pend[2];

  always #5 clk = ~clk;

  hazard_ctrl_seq #(.REG_AW(2), .IGNORE_REG0(1'b1), .LOAD_LAT(3), .MEM_TIMEOUT(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .ex_rd(ex_rd), .mem_rd(mem_rd),
    .wb_rd(wb_rd), .ex_reg_write(ex_rw), .mem_reg_write(mem_rw), .wb_reg_write(wb_rw),
    .ex_mem_read(ex_mem_read), .mem_req(mem_req), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .forward_a(a_fa), .forward_b(a_fb), .stall_if(a_sif),
    .stall_id(a_sid), .stall_ex(a_sex), .stall_mem(a_smem), .bubble_ex(a_bub),
    .flush_id(a_fl), .mem_err(a_err), .stall_cnt(a_cnt)
  );

  hazard_ctrl_seq #(.REG_AW(2), .IGNORE_REG0(1'b0), .LOAD_LAT(1), .MEM_TIMEOUT(15)) dut_b (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .ex_rd(ex_rd), .mem_rd(mem_rd),
    .wb_rd(wb_rd), .ex_reg_write(ex_rw), .mem_reg_write(mem_rw), .wb_reg_write(wb_rw),
    .ex_mem_read(ex_mem_read), .mem_req(mem_req), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .forward_a(b_fa), .forward_b(b_fb), .stall_if(b_sif),
    .stall_id(b_sid), .stall_ex(b_sex), .stall_mem(b_smem), .bubble_ex(b_bub),
    .flush_id(b_fl), .mem_err(b_err), .stall_cnt(b_cnt)
  );

  assign a_live = {a_fa, a_fb, a_sif, a_sid, a_sex, a_smem, a_bub, a_fl, a_err};
  assign b_live = {b_fa, b_fb, b_sif, b_sid, b_sex, b_smem, b_bub, b_fl, b_err};

  function automatic int cfg_lat(input int k);
    return (k == 0) ? 3 : 1;
  endfunction

  function automatic int cfg_tmo(input int k);
    return (k == 0) ? 3 : 15;
  endfunction

  function automatic bit cfg_ign(input int k);
    return (k == 0);
  endfunction

  function automatic bit hit(input int k, input logic [1:0] rd, input logic wr, input logic [1:0] src);
    return wr && (rd == src) && !(cfg_ign(k) && (src == 2'd0));
  endfunction

  function automatic logic [1:0] fwd(input int k, input logic [1:0] src);
    if (hit(k, ex_rd, ex_rw, src))   return 2'b11;
    if (hit(k, mem_rd, mem_rw, src)) return 2'b01;
    if (hit(k, wb_rd, wb_rw, src))   return 2'b10;
    return 2'b00;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected outputs for the current cycle, then advance the model by one clock
  task automatic model_step(input int k, output logic [10:0] eo, output logic [15:0] ec);
    logic [1:0] fa, fb;
    logic       s_fe, s_be, bub, fl, err;
    bit         lu;
    fa = 2'b00; fb = 2'b00; s_fe = 1'b0; s_be = 1'b0; bub = 1'b0; fl = 1'b0; err = 1'b0;
`ifdef HAZARD_PERF_CNT_EN
    ec = 16'(perf[k]);
`else
    ec = 16'h0000;
`endif
    if (!rst_n) begin
      lu_rem[k] = 0; waited[k] = 0; perf[k] = 0; frozen[k] = 1'b0; pend[k] = 1'b0;
      ec = 16'h0000;
    end else begin
      lu = ex_mem_read && (hit(k, ex_rd, ex_rw, id_rs) || hit(k, ex_rd, ex_rw, id_rt));
      if (frozen[k]) begin
        s_fe = 1'b1; s_be = 1'b1;
        if (branch_taken) pend[k] = 1'b1;
        if (mem_ready) begin
          frozen[k] = 1'b0; waited[k] = 0;
        end else if (waited[k] + 1 >= cfg_tmo(k)) begin
          err = 1'b1; frozen[k] = 1'b0; waited[k] = 0; lu_rem[k] = 0;
        end else begin
          waited[k]++;
        end
      end else if (mem_req && !mem_ready) begin
        s_fe = 1'b1; s_be = 1'b1; frozen[k] = 1'b1; waited[k] = 1;
        if (branch_taken) pend[k] = 1'b1;
      end else if (branch_taken || pend[k]) begin
        fl = 1'b1; bub = 1'b1; pend[k] = 1'b0; lu_rem[k] = 0;
      end else if (lu_rem[k] > 0) begin
        s_fe = 1'b1; bub = 1'b1; lu_rem[k]--;
      end else if (lu) begin
        s_fe = 1'b1; bub = 1'b1; lu_rem[k] = cfg_lat(k) - 1;
      end else begin
        fa = fwd(k, id_rs); fb = fwd(k, id_rt);
      end
      if (s_fe && perf[k] < 65535) perf[k]++;
    end
    eo = {fa, fb, s_fe, s_fe, s_be, s_be, bub, fl, err};
  endtask

  task automatic tick();
    logic [10:0] ea, eb;
    logic [15:0] ca, cb;
    @(negedge clk);
    a_o = a_live; b_o = b_live; a_c = a_cnt; b_c = b_cnt;
    model_step(0, ea, ca);
    model_step(1, eb, cb);
    chk("a_outs", 16'(a_o), 16'(ea));
    chk("a_stall_cnt", a_c, ca);
    chk("b_outs", 16'(b_o), 16'(eb));
    chk("b_stall_cnt", b_c, cb);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = 2'd0; id_rt = 2'd0; ex_rd = 2'd0; mem_rd = 2'd0; wb_rd = 2'd0;
    ex_rw = 1'b0; mem_rw = 1'b0; wb_rw = 1'b0; ex_mem_read = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      lu_rem[k] = 0; waited[k] = 0; perf[k] = 0; frozen[k] = 1'b0; pend[k] = 1'b0;
    end
    rst_n = 1'b0;
    clear_inputs();
    tick();
    tick();
    chk("reset_outs_a", 16'(a_o), 16'h0000);
    chk("reset_outs_b", 16'(b_o), 16'h0000);
    rst_n = 1'b1;

    // Forwarding priority EX > MEM > WB
    id_rs = 2'd2; id_rt = 2'd3; ex_rd = 2'd2; ex_rw = 1'b1; mem_rd = 2'd2; mem_rw = 1'b1;
    tick();
    chk("fwd_ex", 16'(a_o[10:9]), 16'h3);
    chk("fwd_b_none", 16'(a_o[8:7]), 16'h0);
    ex_rw = 1'b0;
    tick();
    chk("fwd_mem", 16'(a_o[10:9]), 16'h1);
    mem_rw = 1'b0; wb_rd = 2'd2; wb_rw = 1'b1;
    tick();
    chk("fwd_wb", 16'(a_o[10:9]), 16'h2);

    // Register 0 ignored only in the IGNORE_REG0 configuration
    clear_inputs();
    ex_rw = 1'b1;
    tick();
    chk("reg0_a_fwd", 16'(a_o[10:9]), 16'h0);
    chk("reg0_a_stall", 16'(a_o[6]), 16'h0);
    chk("reg0_b_fwd", 16'(b_o[10:9]), 16'h3);

    // Load-use with LOAD_LAT=3 on dut_a
    clear_inputs();
    id_rs = 2'd3; id_rt = 2'd1; ex_rd = 2'd1; ex_rw = 1'b1; ex_mem_read = 1'b1;
    stall_seen = 0;
    tick();
    if (a_o[6] && a_o[5] && a_o[2]) stall_seen++;
    ex_rw = 1'b0; ex_mem_read = 1'b0; mem_rd = 2'd1; mem_rw = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (a_o[6] && a_o[5] && a_o[2]) stall_seen++;
    end
    chk("lu_stall_cycles", 16'(stall_seen), 16'd3);
    chk("lu_fwd_b_mem", 16'(a_o[8:7]), 16'h1);

    // Memory wait of 4 cycles on dut_b with a branch in the middle
    clear_inputs();
    mem_req = 1'b1;
    stall_seen = 0;
    for (int i = 0; i < 6; i++) begin
      branch_taken = (i == 1);
      mem_ready = (i == 4);
      mem_req = (i < 5);
      tick();
      if (b_o[6] && b_o[5] && b_o[4] && b_o[3]) stall_seen++;
      if (i == 2) chk("a_timeout_in_wait", 16'(a_o[0]), 16'h1);
    end
    chk("b_mem_stall_cycles", 16'(stall_seen), 16'd5);
    chk("b_flush_after_release", 16'(b_o[1]), 16'h1);

    // Timeout on dut_a after 3 wait cycles
    clear_inputs();
    mem_req = 1'b1;
    tick();
    tick();
    chk("a_no_err_early", 16'(a_o[0]), 16'h0);
    tick();
    chk("a_err_3rd_cycle", 16'(a_o[0]), 16'h1);
    mem_req = 1'b0; mem_ready = 1'b1;
    tick();
    chk("a_idle_after_timeout", 16'(a_o[6]), 16'h0);

    // Asynchronous reset while dut_a sits in LU_WAIT
    clear_inputs();
    id_rs = 2'd3; id_rt = 2'd1; ex_rd = 2'd1; ex_rw = 1'b1; ex_mem_read = 1'b1;
    tick();
    chk("lu_wait_live", 16'(a_live[6]), 16'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_a", 16'(a_live), 16'h0000);
    chk("rst_async_b", 16'(b_live), 16'h0000);
    chk("rst_async_cnt", a_cnt, 16'h0000);
    tick();
    rst_n = 1'b1;
    clear_inputs();
    tick();

    // Random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      rst_n        = ($urandom_range(0, 149) != 0);
      id_rs        = 2'($urandom_range(0, 3));
      id_rt        = 2'($urandom_range(0, 3));
      ex_rd        = 2'($urandom_range(0, 3));
      mem_rd       = 2'($urandom_range(0, 3));
      wb_rd        = 2'($urandom_range(0, 3));
      ex_rw        = 1'($urandom_range(0, 1));
      mem_rw       = 1'($urandom_range(0, 1));
      wb_rw        = 1'($urandom_range(0, 1));
      ex_mem_read  = ($urandom_range(0, 2) == 0);
      mem_req      = ($urandom_range(0, 3) == 0);
      mem_ready    = ($urandom_range(0, 2) != 0);
      branch_taken = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
